// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the FIFO slice.
package fifo_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int DEPTH      = 8;

    // Pointer width for a given depth; clamps to 1 so a degenerate depth still elaborates.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: synchronous write, asynchronous read, no reset.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DataWidth = DATA_WIDTH,
    parameter int Depth     = DEPTH,
    localparam int AddrW    = ptr_width(Depth)
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [AddrW-1:0]     waddr_i,
    input  logic [DataWidth-1:0] wdata_i,
    input  logic [AddrW-1:0]     raddr_i,
    output logic [DataWidth-1:0] rdata_o
);

    logic [DataWidth-1:0] mem [Depth];

    // NOTE: the array has no reset; the read side masks stale entries, so a reset would only cost area.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/fifo_interface.sv
// First-word-fall-through FIFO with valid/ready handshakes on both sides.
module fifo_interface
    import fifo_pkg::*;
#(
    parameter int DataWidth = DATA_WIDTH,
    parameter int Depth     = DEPTH
) (
    input  logic                 clk_i,
    input  logic                 arst_i,
    input  logic [DataWidth-1:0] din_i,
    input  logic                 din_val_i,
    output logic                 din_rdy_o,
    output logic [DataWidth-1:0] dout_o,
    output logic                 dout_val_o,
    input  logic                 dout_rdy_i
);

    localparam int PtrW = ptr_width(Depth);
    localparam int CntW = $clog2(Depth) + 1;
    localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

    logic [PtrW-1:0]      wr_ptr;
    logic [PtrW-1:0]      rd_ptr;
    logic [CntW-1:0]      count;
    logic                 full;
    logic                 empty;
    logic                 wr_en;
    logic                 rd_en;
    logic [DataWidth-1:0] rd_data;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        return (ptr == LastPtr) ? '0 : ptr + 1'b1;
    endfunction

    // Flags come from the count register alone, so neither ready depends on the far side's inputs.
    assign full       = (count == FullCnt);
    assign empty      = (count == '0);
    assign din_rdy_o  = ~full;
    assign dout_val_o = ~empty;
    assign wr_en      = din_val_i & ~full;
    assign rd_en      = dout_rdy_i & ~empty;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (rd_en) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    fifo_mem #(
        .DataWidth (DataWidth),
        .Depth     (Depth)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (wr_en),
        .waddr_i (wr_ptr),
        .wdata_i (din_i),
        .raddr_i (rd_ptr),
        .rdata_o (rd_data)
    );

    assign dout_o = empty ? '0 : rd_data;

endmodule

// File: tb/tb_fifo_interface.sv
// Scoreboard bench for fifo_interface: a queue holds the expected contents in write order.
module tb_fifo_interface;

    localparam int DW    = 16;
    localparam int DEPTH = 8;

    logic          clk_i = 1'b0;
    logic          arst_i;
    logic [DW-1:0] din_i;
    logic          din_val_i;
    logic          din_rdy_o;
    logic [DW-1:0] dout_o;
    logic          dout_val_o;
    logic          dout_rdy_i;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] sb[$];

    fifo_interface #(
        .DataWidth (DW),
        .Depth     (DEPTH)
    ) dut (
        .clk_i      (clk_i),
        .arst_i     (arst_i),
        .din_i      (din_i),
        .din_val_i  (din_val_i),
        .din_rdy_o  (din_rdy_o),
        .dout_o     (dout_o),
        .dout_val_o (dout_val_o),
        .dout_rdy_i (dout_rdy_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called at a falling edge: drive inputs, check outputs against the scoreboard,
    // advance through one rising edge, then update the scoreboard.
    task automatic cycle(input logic wv, input logic [DW-1:0] wd, input logic rr);
        logic wr;
        logic rd;
        din_val_i  = wv;
        din_i      = wd;
        dout_rdy_i = rr;
        #1;
        check("din_rdy",  32'(din_rdy_o),  32'(sb.size() < DEPTH));
        check("dout_val", 32'(dout_val_o), 32'(sb.size() > 0));
        check("count",    32'(dut.count),  32'(sb.size()));
        if (sb.size() > 0) check("dout", 32'(dout_o), 32'(sb[0]));
        else               check("dout_empty", 32'(dout_o), 32'h0);
        wr = wv && (sb.size() < DEPTH);
        rd = rr && (sb.size() > 0);
        @(posedge clk_i);
        if (rd) void'(sb.pop_front());
        if (wr) sb.push_back(wd);
        @(negedge clk_i);
    endtask

    task automatic fill();
        for (int i = 1; i <= DEPTH; i++) cycle(1'b1, DW'(i), 1'b0);
    endtask

    task automatic drain();
        while (sb.size() > 0) cycle(1'b0, '0, 1'b1);
    endtask

    initial begin
        arst_i     = 1'b1;
        din_i      = '0;
        din_val_i  = 1'b0;
        dout_rdy_i = 1'b0;
        #3;
        check("rst_rdy",  32'(din_rdy_o),  32'h1);
        check("rst_val",  32'(dout_val_o), 32'h0);
        check("rst_dout", 32'(dout_o),     32'h0);
        @(negedge clk_i);
        arst_i = 1'b0;

        // Fill to full, then an ignored ninth write.
        fill();
        check("fill_full_rdy", 32'(din_rdy_o), 32'h0);
        cycle(1'b1, 16'h0009, 1'b0);
        check("fill_count", 32'(dut.count), 32'(DEPTH));

        // Drain in order, then idle check.
        drain();
        cycle(1'b0, '0, 1'b0);
        check("drain_val", 32'(dout_val_o), 32'h0);
        check("drain_rdy", 32'(din_rdy_o),  32'h1);

        // Single write into empty FIFO: visible the next cycle, gone one after.
        cycle(1'b1, 16'h00AA, 1'b1);
        check("ewr_dout", 32'(dout_o),     32'h00AA);
        check("ewr_val",  32'(dout_val_o), 32'h1);
        cycle(1'b0, '0, 1'b1);
        check("ewr_empty", 32'(dout_val_o), 32'h0);
        cycle(1'b0, '0, 1'b0);

        // Streaming across pointer wrap with occupancy held at one.
        cycle(1'b1, 16'h0100, 1'b1);
        for (int i = 1; i < 20; i++) begin
            check("wrap_count", 32'(dut.count), 32'h1);
            cycle(1'b1, 16'h0100 + DW'(i), 1'b1);
        end
        check("wrap_last", 32'(dout_o), 32'h0113);
        cycle(1'b0, '0, 1'b1);
        check("wrap_empty", 32'(dout_val_o), 32'h0);

        // Full boundary: simultaneous valid/ready reads one, writes none.
        fill();
        cycle(1'b1, 16'h1234, 1'b1);
        check("fb_count", 32'(dut.count), 32'(DEPTH - 1));
        check("fb_rdy",   32'(din_rdy_o), 32'h1);
        cycle(1'b1, 16'h1234, 1'b0);
        check("fb_accept", 32'(dut.count), 32'(DEPTH));
        drain();

        // Mid-operation reset, asserted between edges.
        cycle(1'b1, 16'h0BAD, 1'b0);
        cycle(1'b1, 16'h0BEE, 1'b0);
        din_val_i = 1'b0;
        #2;
        arst_i = 1'b1;
        #1;
        check("mrst_rdy",  32'(din_rdy_o),  32'h1);
        check("mrst_val",  32'(dout_val_o), 32'h0);
        check("mrst_dout", 32'(dout_o),     32'h0);
        sb.delete();
        @(negedge clk_i);
        arst_i = 1'b0;
        cycle(1'b1, 16'h0055, 1'b0);
        check("mrst_first", 32'(dout_o), 32'h0055);
        drain();
        cycle(1'b0, '0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
